// File: rtl/rv_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : rv_pkg                                                     |
// | Description : RV32I opcodes, ALU codes, operand selects, FSM states.     |
// | Revision    : 1.0                                                        |
// +-------------------------------------------------------------------------+
package rv_pkg;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    localparam logic [5:0] c_alu_add    = 6'b000000;
    localparam logic [5:0] c_alu_jal    = 6'b011111;
    localparam logic [5:0] c_alu_jalr   = 6'b111111;
    localparam logic [2:0] c_alu_br_pfx = 3'b010;

    localparam logic [1:0] c_op1_rs1    = 2'b00;
    localparam logic [1:0] c_op1_pc     = 2'b01;
    localparam logic [1:0] c_op1_pc4    = 2'b10;
    localparam logic [1:0] c_op1_zero   = 2'b11;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        case (opc)
            c_opc_lui, c_opc_auipc, c_opc_jal, c_opc_jalr, c_opc_branch,
            c_opc_load, c_opc_store, c_opc_opimm, c_opc_op, c_opc_system:
                is_known_opcode = 1'b1;
            default:
                is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_generator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : imm_generator                                              |
// | Description : Sign-extended I/S/B/U/J immediate from the instruction.    |
// | Revision    : 1.0                                                        |
// +-------------------------------------------------------------------------+
module imm_generator
    import rv_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm32
);

    always_comb begin
        o_imm32 = '0;
        case (i_instr[6:0])
            c_opc_opimm, c_opc_load, c_opc_jalr:
                o_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            c_opc_store:
                o_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            c_opc_branch:
                o_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            c_opc_lui, c_opc_auipc:
                o_imm32 = {i_instr[31:12], 12'h000};
            c_opc_jal:
                o_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            default:
                o_imm32 = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : mc_controller                                              |
// | Description : Multi-cycle RV32I control unit with PC, IR and handshakes. |
// | Revision    : 1.0                                                        |
// +-------------------------------------------------------------------------+
module mc_controller
    import rv_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic [2:0]      load_type,
    input  logic            branch,
    input  logic [PC_W-1:0] jalr_target,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr,
    output logic [4:0]      read_sel1,
    output logic [4:0]      read_sel2,
    output logic [4:0]      write_sel,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            branch_op,
    output logic [1:0]      op1_sel,
    output logic            op2_sel,
    output logic [5:0]      alu_ctrl,
    output logic [31:0]     imm32,
    output logic            ecall,
    input  logic            ecall_ack,
    output logic            illegal
);

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [31:0]     r_ir;
    logic            w_instr_done;

    logic [6:0]      w_opc;
    logic [2:0]      w_funct3;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_alt_op;

    assign w_opc       = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_is_load   = (w_opc == c_opc_load);
    assign w_is_store  = (w_opc == c_opc_store);
    assign w_is_branch = (w_opc == c_opc_branch);
    assign w_is_jal    = (w_opc == c_opc_jal);
    assign w_is_jalr   = (w_opc == c_opc_jalr);

    imm_generator u_imm_generator (
        .i_instr (r_ir),
        .o_imm32 (imm32)
    );

    assign pc         = r_pc;
    assign imem_addr  = r_pc;
    assign instr      = r_ir;
    assign read_sel1  = r_ir[19:15];
    assign read_sel2  = r_ir[24:20];
    assign write_sel  = r_ir[11:7];
    assign load_type  = w_funct3;
    assign mem_to_reg = w_is_load;

    // IR[30] only distinguishes sub/sra; for OP-IMM it is an immediate bit unless shifting
    always_comb begin
        w_alt_op = 1'b0;
        if (w_opc == c_opc_op)
            w_alt_op = r_ir[30] & ((w_funct3 == 3'b000) | (w_funct3 == 3'b101));
        else if (w_opc == c_opc_opimm)
            w_alt_op = r_ir[30] & (w_funct3 == 3'b101);
    end

    always_comb begin
        alu_ctrl  = c_alu_add;
        op1_sel   = c_op1_rs1;
        op2_sel   = 1'b0;
        branch_op = 1'b0;
        case (w_opc)
            c_opc_op: begin
                alu_ctrl = {2'b00, w_alt_op, w_funct3};
            end
            c_opc_opimm: begin
                alu_ctrl = {2'b00, w_alt_op, w_funct3};
                op2_sel  = 1'b1;
            end
            c_opc_load, c_opc_store: begin
                op2_sel  = 1'b1;
            end
            c_opc_branch: begin
                alu_ctrl  = {c_alu_br_pfx, w_funct3};
                branch_op = 1'b1;
            end
            c_opc_lui: begin
                op1_sel  = c_op1_zero;
                op2_sel  = 1'b1;
            end
            c_opc_auipc: begin
                op1_sel  = c_op1_pc;
                op2_sel  = 1'b1;
            end
            c_opc_jal: begin
                alu_ctrl = c_alu_jal;
                op1_sel  = c_op1_pc4;
            end
            c_opc_jalr: begin
                alu_ctrl = c_alu_jalr;
                op1_sel  = c_op1_pc4;
            end
            default: begin
                alu_ctrl = c_alu_add;
            end
        endcase
    end

    // Next PC is only committed on the edge that ends an instruction
    always_comb begin
        if (w_is_jal || (w_is_branch && branch))
            w_pc_next = r_pc + imm32[PC_W-1:0];
        else if (w_is_jalr)
            w_pc_next = jalr_target & ~PC_W'(1);
        else
            w_pc_next = r_pc + PC_W'(4);
    end

    always_comb begin
        w_state_next = r_state;
        w_instr_done = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write    = 1'b0;
        ecall        = 1'b0;
        illegal      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready)
                    w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!is_known_opcode(w_opc))
                    w_state_next = ST_TRAP;
                else if (w_opc == c_opc_system)
                    w_state_next = ST_HALT;
                else
                    w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_is_load || w_is_store) begin
                    w_state_next = ST_MEM;
                end else if (w_is_branch) begin
                    w_state_next = ST_FETCH;
                    w_instr_done = 1'b1;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ready) begin
                    if (w_is_load) begin
                        w_state_next = ST_WB;
                    end else begin
                        w_state_next = ST_FETCH;
                        w_instr_done = 1'b1;
                    end
                end
            end
            ST_WB: begin
                reg_write    = 1'b1;
                w_state_next = ST_FETCH;
                w_instr_done = 1'b1;
            end
            ST_HALT: begin
                ecall = 1'b1;
                if (ecall_ack) begin
                    w_state_next = ST_FETCH;
                    w_instr_done = 1'b1;
                end
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= c_nop_instr;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_FETCH && imem_ready)
                r_ir <= imem_rdata;
            if (w_instr_done)
                r_pc <= w_pc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_mc_controller                                           |
// | Description : Table-driven scoreboard bench for mc_controller.           |
// | Revision    : 1.0                                                        |
// +-------------------------------------------------------------------------+
module tb_mc_controller;

    typedef struct {
        logic [31:0] ins;
        int          iw;
        int          dw;
        logic        br;
        logic [15:0] jt;
        int          cyc;
        logic [15:0] pc_after;
        int          rw;
        logic        m2r;
        int          dreq;
        int          dwe;
        logic [5:0]  alu;
        logic [1:0]  o1;
        logic        o2;
        logic        bop;
        logic [4:0]  rd;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] pc_after;
        int          rw;
        int          rw_cyc;
        logic        m2r;
        int          dreq;
        int          dwe;
        logic [5:0]  alu;
        logic [1:0]  o1;
        logic        o2;
        logic        bop;
        logic [4:0]  rd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic [2:0]  load_type;
    logic        branch;
    logic [15:0] jalr_target;
    logic [15:0] pc;
    logic [31:0] instr;
    logic [4:0]  read_sel1;
    logic [4:0]  read_sel2;
    logic [4:0]  write_sel;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch_op;
    logic [1:0]  op1_sel;
    logic        op2_sel;
    logic [5:0]  alu_ctrl;
    logic [31:0] imm32;
    logic        ecall;
    logic        ecall_ack;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[13];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    mc_controller #(.PC_W(16), .RESET_PC(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .load_type(load_type), .branch(branch), .jalr_target(jalr_target),
        .pc(pc), .instr(instr), .read_sel1(read_sel1), .read_sel2(read_sel2),
        .write_sel(write_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .branch_op(branch_op), .op1_sel(op1_sel), .op2_sel(op2_sel),
        .alu_ctrl(alu_ctrl), .imm32(imm32), .ecall(ecall), .ecall_ack(ecall_ack),
        .illegal(illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Serves one instruction from its first FETCH cycle until the next FETCH
    task automatic run_instr(input vec_t v, output obs_t o);
        int k, wi, wd;
        bit fetched, dec_seen, done;
        o = '{default: 0};
        k = 0; wi = 0; wd = 0;
        fetched = 0; dec_seen = 0; done = 0;
        branch = v.br;
        jalr_target = v.jt;
        while (!done && k < 64) begin
            @(negedge clk);
            k++;
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req) begin
                if (fetched) begin
                    done = 1;
                    o.cyc = k - 1;
                    o.pc_after = pc;
                end else if (wi == v.iw) begin
                    imem_ready = 1'b1;
                    imem_rdata = v.ins;
                    fetched = 1;
                end else begin
                    wi++;
                end
            end else if (fetched) begin
                if (!dec_seen) begin
                    dec_seen = 1;
                    o.alu = alu_ctrl;
                    o.o1  = op1_sel;
                    o.o2  = op2_sel;
                    o.bop = branch_op;
                    o.rd  = write_sel;
                end
                if (dmem_req) begin
                    o.dreq++;
                    if (dmem_we) o.dwe++;
                    if (wd == v.dw) dmem_ready = 1'b1;
                    else wd++;
                end
                if (reg_write) begin
                    o.rw++;
                    o.rw_cyc = k;
                    o.m2r = mem_to_reg;
                end
            end
        end
        chk("instr_timeout", {31'd0, done}, 32'd1);
        branch = 1'b0;
    endtask

    task automatic check_vec(input int i, input obs_t o, input vec_t e);
        chk($sformatf("v%0d_cycles", i), o.cyc, e.cyc);
        chk($sformatf("v%0d_pc", i), {16'd0, o.pc_after}, {16'd0, e.pc_after});
        chk($sformatf("v%0d_reg_write_cnt", i), o.rw, e.rw);
        chk($sformatf("v%0d_reg_write_cycle", i), o.rw_cyc, (e.rw != 0) ? e.cyc : 0);
        chk($sformatf("v%0d_mem_to_reg", i), {31'd0, o.m2r}, {31'd0, e.m2r});
        chk($sformatf("v%0d_dmem_req_cnt", i), o.dreq, e.dreq);
        chk($sformatf("v%0d_dmem_we_cnt", i), o.dwe, e.dwe);
        chk($sformatf("v%0d_alu_ctrl", i), {26'd0, o.alu}, {26'd0, e.alu});
        chk($sformatf("v%0d_op1_sel", i), {30'd0, o.o1}, {30'd0, e.o1});
        chk($sformatf("v%0d_op2_sel", i), {31'd0, o.o2}, {31'd0, e.o2});
        chk($sformatf("v%0d_branch_op", i), {31'd0, o.bop}, {31'd0, e.bop});
        chk($sformatf("v%0d_write_sel", i), {27'd0, o.rd}, {27'd0, e.rd});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        obs_t o;
        vec_t e;
        int halt_cycles;
        int req_cnt;
        int ill_cnt;

        //            ins           iw dw br  jt       cyc pc_after  rw m2r dreq dwe alu     o1 o2 bop rd
        vecs[0]  = '{32'hF01FF0EF, 0, 0, 0, 16'h0000, 4, 16'h0000, 1, 0, 0, 0, 6'h1F, 2, 0, 0, 5'd1};
        vecs[1]  = '{32'h00500093, 0, 0, 0, 16'h0000, 4, 16'h0004, 1, 0, 0, 0, 6'h00, 0, 1, 0, 5'd1};
        vecs[2]  = '{32'hFE208CE3, 2, 0, 1, 16'h0000, 5, 16'hFFFC, 0, 0, 0, 0, 6'h10, 0, 0, 1, 5'd25};
        vecs[3]  = '{32'h0040A183, 0, 3, 0, 16'h0000, 8, 16'h0000, 1, 1, 4, 0, 6'h00, 0, 1, 0, 5'd3};
        vecs[4]  = '{32'h0020A423, 0, 0, 0, 16'h0000, 4, 16'h0004, 0, 0, 1, 1, 6'h00, 0, 1, 0, 5'd8};
        vecs[5]  = '{32'h407302B3, 1, 0, 0, 16'h0000, 5, 16'h0008, 1, 0, 0, 0, 6'h08, 0, 0, 0, 5'd5};
        vecs[6]  = '{32'h4030D093, 0, 0, 0, 16'h0000, 4, 16'h000C, 1, 0, 0, 0, 6'h0D, 0, 1, 0, 5'd1};
        vecs[7]  = '{32'h00209863, 0, 0, 0, 16'h0000, 3, 16'h0010, 0, 0, 0, 0, 6'h11, 0, 0, 1, 5'd16};
        vecs[8]  = '{32'h12345237, 0, 0, 0, 16'h0000, 4, 16'h0014, 1, 0, 0, 0, 6'h00, 3, 1, 0, 5'd4};
        vecs[9]  = '{32'h00001217, 0, 0, 0, 16'h0000, 4, 16'h0018, 1, 0, 0, 0, 6'h00, 1, 1, 0, 5'd4};
        vecs[10] = '{32'h000280E7, 0, 0, 0, 16'h0123, 4, 16'h0122, 1, 0, 0, 0, 6'h3F, 2, 0, 0, 5'd1};
        vecs[11] = '{32'h003120B3, 0, 0, 0, 16'h0000, 4, 16'h0126, 1, 0, 0, 0, 6'h02, 0, 0, 0, 5'd1};
        vecs[12] = '{32'h40000093, 0, 0, 1, 16'h0000, 4, 16'h012A, 1, 0, 0, 0, 6'h00, 0, 1, 0, 5'd1};

        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;
        dmem_ready = 1'b0; branch = 1'b0; jalr_target = '0; ecall_ack = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_pc", {16'd0, pc}, 32'h0100);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_ecall", {31'd0, ecall}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_imem_addr", {16'd0, imem_addr}, 32'h0100);
        chk("post_rst_imem_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(vecs[i]);
            run_instr(vecs[i], o);
            e = exp_q.pop_front();
            check_vec(i, o, e);
        end

        // ECALL: ack asserted before HALT must not skip the halt
        @(negedge clk);
        chk("ecall_fetch_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0073; ecall_ack = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("ecall_decode_ecall", {31'd0, ecall}, 32'd0);
        @(negedge clk);
        chk("ecall_halt_entry", {31'd0, ecall}, 32'd1);
        ecall_ack = 1'b0;
        halt_cycles = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (ecall) halt_cycles++;
        end
        chk("ecall_held_cycles", halt_cycles, 4);
        chk("ecall_pc_held", {16'd0, pc}, 32'h012A);
        ecall_ack = 1'b1;
        @(negedge clk);
        ecall_ack = 1'b0;
        chk("ecall_released", {31'd0, ecall}, 32'd0);
        chk("ecall_refetch", {31'd0, imem_req}, 32'd1);
        chk("ecall_pc_plus4", {16'd0, pc}, 32'h012E);

        // Illegal opcode: sticky trap, no more fetches
        imem_ready = 1'b1; imem_rdata = 32'h0000_007F;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("illegal_decode", {31'd0, illegal}, 32'd0);
        req_cnt = 0; ill_cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
            if (illegal) ill_cnt++;
        end
        chk("illegal_sticky", ill_cnt, 8);
        chk("illegal_no_fetch", req_cnt, 0);
        chk("illegal_no_reg_write", {31'd0, reg_write}, 32'd0);

        // Reset clears the trap; one more instruction from the reset vector
        rst_n = 1'b0;
        #2;
        chk("rerst_illegal", {31'd0, illegal}, 32'd0);
        chk("rerst_pc", {16'd0, pc}, 32'h0100);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{32'h00500093, 0, 0, 0, 16'h0000, 4, 16'h0104, 1, 0, 0, 0, 6'h00, 0, 1, 0, 5'd1};
        exp_q.push_back(e);
        run_instr(e, o);
        e = exp_q.pop_front();
        check_vec(13, o, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
